sopc_irq_clk_ctrl: RTL and testbench

Parametrised clock-and-interrupt front end for the test SOPC. It generates the divided CPU clock with a matching single-cycle enable strobe, and synchronises NUM_IRQ asynchronous interrupt sources (UARTs, keyboard, timer). Each source is latched as either level or rising-edge, masked, and presented to the CPU on an int vector that changes only mid-CPU-period. It sits between the board inputs and the CPU's int_i port. It replaces the hard-wired toggle-flop divider chain and raw interrupt concatenation.

---
 rtl/sopc_irq_clk_ctrl_if.sv | 23 ++
 rtl/sopc_irq_clk_ctrl.sv | 70 +++++++
 tb/tb_sopc_irq_clk_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/sopc_irq_clk_ctrl_if.sv
// Bundle of interrupt inputs and CPU-side clock/interrupt outputs of sopc_irq_clk_ctrl.
// The slave modport is the controller; the master modport is the board/CPU side.
interface sopc_irq_clk_ctrl_if #(
  parameter int NUM_IRQ = 6
);
  logic [NUM_IRQ-1:0] irq_i;
  logic [NUM_IRQ-1:0] irq_mask_i;
  logic [NUM_IRQ-1:0] irq_ack_i;
  logic               cpu_clk_o;
  logic               cpu_ce_o;
  logic [NUM_IRQ-1:0] int_o;
  logic [NUM_IRQ-1:0] pending_o;

  modport master (
    output irq_i, irq_mask_i, irq_ack_i,
    input  cpu_clk_o, cpu_ce_o, int_o, pending_o
  );

  modport slave (
    input  irq_i, irq_mask_i, irq_ack_i,
    output cpu_clk_o, cpu_ce_o, int_o, pending_o
  );
endinterface

// File: rtl/sopc_irq_clk_ctrl.sv
// CPU clock divider with single-cycle enable, plus synchronised, maskable level/edge
// interrupt latching whose CPU-facing vector only changes on cpu_clk_o falling edges.
module sopc_irq_clk_ctrl #(
  parameter int                 DIV_LOG2    = 3,
  parameter int                 NUM_IRQ     = 6,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK   = NUM_IRQ'(6'b011010)
) (
  input logic                clk,
  input logic                rst,
  sopc_irq_clk_ctrl_if.slave bus
);

  localparam logic [DIV_LOG2-1:0] CE_CNT  = DIV_LOG2'((1 << (DIV_LOG2 - 1)) - 1);
  localparam logic [DIV_LOG2-1:0] UPD_CNT = '1;

  logic [DIV_LOG2-1:0] cnt_q, cnt_d;
  logic [NUM_IRQ-1:0]  sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0]  sync_d [SYNC_STAGES];
  logic [NUM_IRQ-1:0]  s_dly_q, s_dly_d;
  logic [NUM_IRQ-1:0]  pending_q, pending_d;
  logic [NUM_IRQ-1:0]  int_q, int_d;
  logic [NUM_IRQ-1:0]  s, rise, edge_next, level_next;
  logic                upd;

  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    upd       = (cnt_q == UPD_CNT);
    sync_d[0] = bus.irq_i;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    s       = sync_q[SYNC_STAGES-1];
    s_dly_d = s;
    rise    = s & ~s_dly_q;
    // ack is applied before the set so a same-cycle edge wins
    edge_next  = (pending_q & ~({NUM_IRQ{upd}} & bus.irq_ack_i)) | rise;
    // sampling one stage early keeps level pending cycle-aligned with s
    level_next = sync_q[SYNC_STAGES-2];
    pending_d  = (edge_next & EDGE_MASK) | (level_next & ~EDGE_MASK);
    int_d      = upd ? (pending_q & ~bus.irq_mask_i) : int_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      s_dly_q   <= '0;
      pending_q <= '0;
      int_q     <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      s_dly_q   <= s_dly_d;
      pending_q <= pending_d;
      int_q     <= int_d;
    end
  end

  assign bus.cpu_clk_o = cnt_q[DIV_LOG2-1];
  // gated so the strobe is low in reset even when CE_CNT is zero (DIV_LOG2=1)
  assign bus.cpu_ce_o  = rst & (cnt_q == CE_CNT);
  assign bus.int_o     = int_q;
  assign bus.pending_o = pending_q;

endmodule

// File: tb/tb_sopc_irq_clk_ctrl.sv
// Bench for sopc_irq_clk_ctrl: default instance plus a DIV_LOG2=1 / 32-channel instance,
// both compared every cycle against a history-based behavioural model.
module tb_sopc_irq_clk_ctrl;

  localparam logic [31:0] EM_B = 32'hC35A_0F96;

  logic clk;
  logic rst;

  sopc_irq_clk_ctrl_if #(.NUM_IRQ(6))  busa ();
  sopc_irq_clk_ctrl_if #(.NUM_IRQ(32)) busb ();

  sopc_irq_clk_ctrl #(
    .DIV_LOG2(3), .NUM_IRQ(6), .SYNC_STAGES(2), .EDGE_MASK(6'b011010)
  ) dut_a (.clk(clk), .rst(rst), .bus(busa));

  sopc_irq_clk_ctrl #(
    .DIV_LOG2(1), .NUM_IRQ(32), .SYNC_STAGES(3), .EDGE_MASK(EM_B)
  ) dut_b (.clk(clk), .rst(rst), .bus(busb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int          dlog [2] = '{3, 1};
  int          sst  [2] = '{2, 3};
  logic [31:0] em   [2] = '{32'h0000_001A, EM_B};
  logic [31:0] wm   [2] = '{32'h0000_003F, 32'hFFFF_FFFF};

  int          edges [2];
  logic [31:0] pend  [2];
  logic [31:0] intv  [2];
  logic [31:0] hist  [2][8];
  logic [31:0] irq_v, mask_v, ack_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      edges[i] = 0;
      pend[i]  = '0;
      intv[i]  = '0;
      for (int k = 0; k < 8; k++) hist[i][k] = '0;
    end
  endtask

  // hist[i][k] = irq value driven k+1 cycles before the edge being modelled
  task automatic model_edge(input int i);
    int          p, s;
    logic        upd_m;
    logic [31:0] rise, lvl, nx;
    p     = 1 << dlog[i];
    s     = sst[i];
    upd_m = (edges[i] % p) == (p - 1);
    for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k-1];
    hist[i][0] = irq_v & wm[i];
    rise = hist[i][s] & ~hist[i][s+1];
    lvl  = hist[i][s-1];
    nx   = pend[i];
    if (upd_m) begin
      nx      = nx & ~ack_v;
      intv[i] = pend[i] & ~mask_v & wm[i];
    end
    nx       = ((nx | rise) & em[i]) | (lvl & ~em[i]);
    pend[i]  = nx & wm[i];
    edges[i] = edges[i] + 1;
  endtask

  task automatic check_all();
    int p, c;
    logic [31:0] o_clk, o_ce, o_pend, o_int;
    for (int i = 0; i < 2; i++) begin
      p = 1 << dlog[i];
      c = edges[i] % p;
      if (i == 0) begin
        o_clk = 32'(busa.cpu_clk_o); o_ce = 32'(busa.cpu_ce_o);
        o_pend = 32'(busa.pending_o); o_int = 32'(busa.int_o);
      end else begin
        o_clk = 32'(busb.cpu_clk_o); o_ce = 32'(busb.cpu_ce_o);
        o_pend = busb.pending_o; o_int = busb.int_o;
      end
      chk($sformatf("inst%0d_cpu_clk", i), o_clk, 32'(c >= p / 2));
      chk($sformatf("inst%0d_cpu_ce", i), o_ce, 32'(c == p / 2 - 1));
      chk($sformatf("inst%0d_pending", i), o_pend, pend[i]);
      chk($sformatf("inst%0d_int", i), o_int, intv[i]);
    end
  endtask

  task automatic drive(input logic [31:0] irq, input logic [31:0] mask, input logic [31:0] ack);
    irq_v = irq; mask_v = mask; ack_v = ack;
    busa.irq_i = irq[5:0]; busa.irq_mask_i = mask[5:0]; busa.irq_ack_i = ack[5:0];
    busb.irq_i = irq;      busb.irq_mask_i = mask;      busb.irq_ack_i = ack;
  endtask

  // called at a negedge: drive, take one posedge, then check at the next negedge
  task automatic step(input logic [31:0] irq, input logic [31:0] mask, input logic [31:0] ack);
    drive(irq, mask, ack);
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    check_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a_clk"},  32'(busa.cpu_clk_o), 32'd0);
    chk({tag, "_a_ce"},   32'(busa.cpu_ce_o),  32'd0);
    chk({tag, "_a_pend"}, 32'(busa.pending_o), 32'd0);
    chk({tag, "_a_int"},  32'(busa.int_o),     32'd0);
    chk({tag, "_b_clk"},  32'(busb.cpu_clk_o), 32'd0);
    chk({tag, "_b_ce"},   32'(busb.cpu_ce_o),  32'd0);
    chk({tag, "_b_pend"}, busb.pending_o,      32'd0);
    chk({tag, "_b_int"},  busb.int_o,          32'd0);
  endtask

  // reset asserted between clock edges; outputs must clear before any edge arrives
  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    #1 check_zero(tag);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int          first;
    logic [31:0] ir, mk, ak;
    rst = 1'b0;
    drive('0, '0, '0);
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    // first cpu_clk_o rise must land on edge 4 after release
    first = -1;
    for (int e = 1; e <= 20 && first < 0; e++) begin
      step('0, '0, '0);
      if (busa.cpu_clk_o) first = e;
    end
    chk("first_rise_edge", 32'(first), 32'd4);
    repeat (12) step('0, '0, '0);

    // edge channel 4: 3-cycle pulse, latch, present, then ack
    repeat (3) step(32'h10, '0, '0);
    chk("edge4_pending", 32'(busa.pending_o[4]), 32'd1);
    repeat (8) step('0, '0, '0);
    chk("edge4_int_set", 32'(busa.int_o[4]), 32'd1);
    repeat (8) step('0, '0, 32'h10);
    repeat (8) step('0, '0, '0);
    chk("edge4_int_clr", 32'(busa.int_o[4]), 32'd0);

    // level channel 0 held 20 cycles with ack asserted (ack must be ignored)
    repeat (20) step(32'h1, '0, 32'h1);
    chk("level0_pending", 32'(busa.pending_o[0]), 32'd1);
    repeat (12) step('0, '0, '0);
    chk("level0_int_drop", 32'(busa.int_o[0]), 32'd0);

    // mask channel 3, then unmask
    repeat (3) step(32'h8, 32'h8, '0);
    repeat (10) step('0, 32'h8, '0);
    chk("mask3_pending", 32'(busa.pending_o[3]), 32'd1);
    chk("mask3_int_low", 32'(busa.int_o[3]), 32'd0);
    repeat (8) step('0, '0, '0);
    chk("mask3_int_unmasked", 32'(busa.int_o[3]), 32'd1);

    // channel 1 set lands on the upd edge together with its ack
    for (int g = 0; g < 8 && (edges[0] % 8) != 5; g++) step('0, '0, '0);
    step(32'h2, '0, '0);
    step(32'h2, '0, '0);
    step(32'h2, '0, 32'h2);
    chk("collision_pending1", 32'(busa.pending_o[1]), 32'd1);
    repeat (2) step(32'h2, '0, '0);
    repeat (8) step('0, '0, 32'h2);
    chk("ack1_cleared", 32'(busa.pending_o[1]), 32'd0);

    // async reset at cnt=5 with pending 011011
    repeat (12) step(32'h1B, '0, '0);
    for (int g = 0; g < 8 && (edges[0] % 8) != 5; g++) step(32'h1B, '0, '0);
    chk("prereset_pending", 32'(busa.pending_o), 32'h1B);
    chk("prereset_cnt5_clk", 32'(busa.cpu_clk_o), 32'd1);
    async_reset("midrun");
    drive('0, '0, '0);

    // randomized phase with one randomly-timed reset
    ir = '0; mk = '0; ak = '0;
    for (int n = 0; n < 500; n++) begin
      ir = ir ^ ($urandom & $urandom & $urandom);
      if ($urandom_range(0, 7) == 0) mk = $urandom;
      ak = $urandom & $urandom;
      step(ir, mk, ak);
      if (n == 250 + int'($urandom_range(0, 7))) async_reset("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
